miriscv_imem_arbiter: RTL and testbench

Shares the single instruction-memory port (req/addr out, rvalid/rdata in, in-order responses, no grant from memory) between the fetch unit and a secondary reader (debug/loader). It tracks in-flight requests in an ID FIFO and routes each response to its owner. On a pipeline kill it discards in-flight fetch responses. It sits between miriscv_fetch_unit and the core's instruction memory port.

---
 rtl/miriscv_imem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_miriscv_imem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_imem_arbiter.sv
// Instruction-memory port arbiter.
//
// Shares one in-order, grant-less instruction memory port between the fetch
// unit (F) and a secondary reader such as a debug module or loader (D).
// Each issued request records its owner in a small ID FIFO. Every memory
// response pops the head entry and is steered to that owner. A fetch flush
// marks all in-flight fetch entries as discard, so their responses are
// dropped without being delivered.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   f_req_i/f_addr_i/f_flush_i        fetch request, address, kill
//   f_gnt_o/f_rvalid_o/f_rdata_o      fetch issue strobe and response
//   d_req_i/d_addr_i                  secondary request and address
//   d_gnt_o/d_rvalid_o/d_rdata_o      secondary issue strobe and response
//   instr_req_o/instr_addr_o          memory request
//   instr_rvalid_i/instr_rdata_i      memory response (in order)
//   outstanding_o                     number of requests in flight
//   protocol_err_o                    sticky: response with nothing in flight
module miriscv_imem_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // Fetch port
  input  logic                                   f_req_i,
  input  logic [XLEN-1:0]                        f_addr_i,
  input  logic                                   f_flush_i,
  output logic                                   f_gnt_o,
  output logic                                   f_rvalid_o,
  output logic [XLEN-1:0]                        f_rdata_o,
  // Secondary port
  input  logic                                   d_req_i,
  input  logic [XLEN-1:0]                        d_addr_i,
  output logic                                   d_gnt_o,
  output logic                                   d_rvalid_o,
  output logic [XLEN-1:0]                        d_rdata_o,
  // Instruction memory port
  output logic                                   instr_req_o,
  output logic [XLEN-1:0]                        instr_addr_o,
  input  logic                                   instr_rvalid_i,
  input  logic [XLEN-1:0]                        instr_rdata_i,
  // Status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [StvW-1:0] StvMax  = StvW'(STARVE_LIMIT);

  // ID FIFO storage: per-entry valid, owner (1 = secondary) and discard flag.
  logic [MAX_OUTSTANDING-1:0] vld_q, vld_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [MAX_OUTSTANDING-1:0] disc_q, disc_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [StvW-1:0]            starve_q, starve_d;
  logic                       err_q, err_d;

  logic fifo_empty;
  logic pop;
  logic push;
  logic cap;
  logic f_elig;
  logic d_prio;
  logic f_gnt;
  logic d_gnt;
  logic head_is_d;
  logic head_drop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Arbitration and response steering, all zero-latency.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    pop        = instr_rvalid_i & ~fifo_empty;
    // A response popping this cycle frees a slot for a same-cycle issue.
    cap        = (cnt_q < MaxCnt) | pop;
    f_elig     = f_req_i & ~f_flush_i;
    // D wins when F is not competing, or once it has waited long enough.
    d_prio     = d_req_i & (~f_elig | (starve_q == StvMax));
    f_gnt      = ~rst_i & cap & f_elig & ~d_prio;
    d_gnt      = ~rst_i & cap & d_prio;
    push       = f_gnt | d_gnt;

    head_is_d  = id_q[rd_ptr_q];
    // A flush also kills the fetch response arriving in the same cycle.
    head_drop  = disc_q[rd_ptr_q] | f_flush_i;

    f_gnt_o    = f_gnt;
    d_gnt_o    = d_gnt;
    instr_req_o = push;
    if (f_gnt) begin
      instr_addr_o = f_addr_i;
    end else if (d_gnt) begin
      instr_addr_o = d_addr_i;
    end else begin
      instr_addr_o = '0;
    end

    f_rvalid_o = ~rst_i & pop & ~head_is_d & ~head_drop;
    d_rvalid_o = ~rst_i & pop & head_is_d;
    f_rdata_o  = f_rvalid_o ? instr_rdata_i : '0;
    d_rdata_o  = d_rvalid_o ? instr_rdata_i : '0;

    outstanding_o  = cnt_q;
    protocol_err_o = err_q;
  end

  // FIFO, counter and status next-state.
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    disc_d   = disc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (f_flush_i) begin
      disc_d = disc_q | (vld_q & ~id_q);
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    // When full, a simultaneous push reuses the slot just popped.
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      id_d[wr_ptr_q]   = d_gnt;
      disc_d[wr_ptr_q] = 1'b0;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (d_req_i && !d_gnt) begin
      starve_d = (starve_q == StvMax) ? starve_q : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end

    err_d = err_q | (instr_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      id_q     <= '0;
      disc_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      id_q     <= id_d;
      disc_q   <= disc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_miriscv_imem_arbiter.sv
// Bench for miriscv_imem_arbiter: memory model with programmable latency,
// response scoreboard keyed on issue order, table of single-cycle arbitration
// vectors and hand-written multi-cycle sequences.
module tb_miriscv_imem_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 2;
  localparam int STV  = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              f_req_i, f_flush_i, d_req_i;
  logic [XLEN-1:0]   f_addr_i, d_addr_i;
  logic              f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o;
  logic [XLEN-1:0]   f_rdata_o, d_rdata_o;
  logic              instr_req_o;
  logic [XLEN-1:0]   instr_addr_o;
  logic              instr_rvalid_i;
  logic [XLEN-1:0]   instr_rdata_i;
  logic [$clog2(MAXO+1)-1:0] outstanding_o;
  logic              protocol_err_o;

  always #5 clk = ~clk;

  miriscv_imem_arbiter #(
    .XLEN            (XLEN),
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (STV)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .f_req_i        (f_req_i),
    .f_addr_i       (f_addr_i),
    .f_flush_i      (f_flush_i),
    .f_gnt_o        (f_gnt_o),
    .f_rvalid_o     (f_rvalid_o),
    .f_rdata_o      (f_rdata_o),
    .d_req_i        (d_req_i),
    .d_addr_i       (d_addr_i),
    .d_gnt_o        (d_gnt_o),
    .d_rvalid_o     (d_rvalid_o),
    .d_rdata_o      (d_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .outstanding_o  (outstanding_o),
    .protocol_err_o (protocol_err_o)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        drop;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic        f_req;
    logic        f_flush;
    logic        d_req;
    logic [31:0] fa;
    logic [31:0] da;
    logic        f_gnt;
    logic        d_gnt;
    logic [31:0] addr;
  } vec_t;

  exp_t        sb[$];
  mem_t        mq[$];
  int unsigned cyc      = 0;
  int unsigned lat      = 1;
  logic        force_rv = 1'b0;
  logic        err_exp  = 1'b0;
  int          checks   = 0;
  int          errors   = 0;
  int          f_seen   = 0;
  int          d_seen   = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                       input logic dr, input logic [31:0] da);
    f_req_i   = fr;
    f_addr_i  = fa;
    f_flush_i = fl;
    d_req_i   = dr;
    d_addr_i  = da;
  endtask

  // Memory model: in-order responses lat cycles after the issuing cycle.
  initial begin
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mq[0].data;
        mq.delete(0);
      end else if (force_rv) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEAD_BEEF;
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
      end
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    exp_t e;
    logic fexp, dexp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("outstanding", 32'(outstanding_o), sb.size());
      chk("protocol_err", 32'(protocol_err_o), 32'(err_exp));
      if (rst_i) begin
        chk("rst_strobes", {f_gnt_o, d_gnt_o, instr_req_o, f_rvalid_o, d_rvalid_o}, 0);
        chk("rst_data", f_rdata_o | d_rdata_o | instr_addr_o, 0);
        sb.delete();
        mq.delete();
        err_exp = 1'b0;
      end else begin
        if (f_flush_i) begin
          foreach (sb[i]) if (!sb[i].is_d) sb[i].drop = 1'b1;
        end
        if (instr_rvalid_i) begin
          if (sb.size() == 0) begin
            chk("orphan_rvalid", {f_rvalid_o, d_rvalid_o}, 0);
            err_exp = 1'b1;
          end else begin
            e    = sb.pop_front();
            fexp = !e.is_d && !e.drop;
            dexp = e.is_d;
            chk("f_rvalid", 32'(f_rvalid_o), 32'(fexp));
            chk("d_rvalid", 32'(d_rvalid_o), 32'(dexp));
            chk("f_rdata", f_rdata_o, fexp ? e.data : 32'h0);
            chk("d_rdata", d_rdata_o, dexp ? e.data : 32'h0);
            if (fexp && f_rvalid_o && f_rdata_o == e.data) f_seen++;
            if (dexp && d_rvalid_o && d_rdata_o == e.data) d_seen++;
          end
        end else begin
          chk("idle_rvalid", {f_rvalid_o, d_rvalid_o}, 0);
        end
        chk("single_gnt", 32'(f_gnt_o & d_gnt_o), 0);
        chk("instr_req", 32'(instr_req_o), 32'(f_gnt_o | d_gnt_o));
        if (f_gnt_o) sb.push_back('{1'b0, mdata(f_addr_i), 1'b0});
        if (d_gnt_o) sb.push_back('{1'b1, mdata(d_addr_i), 1'b0});
        if (instr_req_o) mq.push_back('{cyc + lat, mdata(instr_addr_o)});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int   f0, d0;
    logic dexp;
    logic [1:0] t3[6];

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_1000};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'h0000_2004, 1'b0, 1'b1, 32'h0000_2004};
    vt[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_2010, 1'b1, 1'b0, 32'h0000_1010};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_1020, 32'h0000_2020, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_1030, 32'h0000_2050, 1'b0, 1'b1, 32'h0000_2050};

    rst_i = 1'b1;
    drive(1'b1, 32'h80, 1'b0, 1'b1, 32'h90);
    tick();
    tick();
    rst_i = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    tick();

    // Single-cycle arbitration vectors from idle.
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].f_req, vt[i].fa, vt[i].f_flush, vt[i].d_req, vt[i].da);
      @(negedge clk);
      chk($sformatf("vec%0d_f_gnt", i), 32'(f_gnt_o), 32'(vt[i].f_gnt));
      chk($sformatf("vec%0d_d_gnt", i), 32'(d_gnt_o), 32'(vt[i].d_gnt));
      chk($sformatf("vec%0d_addr", i), instr_addr_o, vt[i].addr);
      tick();
      drive(1'b0, 0, 1'b0, 1'b0, 0);
      tick();
      tick();
    end

    // F-only stream, latency 1.
    f0 = f_seen;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h80 + 32'(4 * k), 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("t1_f_gnt", 32'(f_gnt_o), 1);
      chk("t1_out_le1", 32'(outstanding_o <= 1), 1);
      tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk("t1_delivered", f_seen - f0, 3);

    // F and D both requesting: D gets every fifth slot.
    f0 = f_seen;
    d0 = d_seen;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b1, 32'h200 + 32'(4 * k));
      dexp = ((k % 5) == 4);
      @(negedge clk);
      chk($sformatf("t2_f_gnt%0d", k), 32'(f_gnt_o), 32'(!dexp));
      chk($sformatf("t2_d_gnt%0d", k), 32'(d_gnt_o), 32'(dexp));
      tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk("t2_f_delivered", f_seen - f0, 8);
    chk("t2_d_delivered", d_seen - d0, 2);

    // Latency 3 with two slots: issue, issue, stall, then pop+push.
    lat = 3;
    f0 = f_seen;
    t3 = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0, 0);
      @(negedge clk);
      chk($sformatf("t3_f_gnt%0d", k), 32'(f_gnt_o), 32'(t3[k]));
      if (k >= 2) chk($sformatf("t3_out%0d", k), 32'(outstanding_o), 2);
      tick();
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (6) tick();
    chk("t3_delivered", f_seen - f0, 4);

    // Flush with two F in flight; D issued in the flush cycle survives.
    f0 = f_seen;
    d0 = d_seen;
    drive(1'b1, 32'h400, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t4_gnt0", 32'(f_gnt_o), 1);
    tick();
    drive(1'b1, 32'h404, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t4_gnt1", 32'(f_gnt_o), 1);
    tick();
    drive(1'b0, 0, 1'b0, 1'b1, 32'h500);
    @(negedge clk);
    chk("t4_full_d_wait", 32'(d_gnt_o), 0);
    tick();
    drive(1'b1, 32'h408, 1'b1, 1'b1, 32'h500);
    @(negedge clk);
    chk("t4_flush_rsp_arrives", 32'(instr_rvalid_i), 1);
    chk("t4_flush_f_gnt", 32'(f_gnt_o), 0);
    chk("t4_flush_d_gnt", 32'(d_gnt_o), 1);
    chk("t4_flush_f_rvalid", 32'(f_rvalid_o), 0);
    tick();
    drive(1'b1, 32'h40C, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t4_post_rsp_arrives", 32'(instr_rvalid_i), 1);
    chk("t4_post_f_gnt", 32'(f_gnt_o), 1);
    chk("t4_post_f_rvalid", 32'(f_rvalid_o), 0);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (6) tick();
    chk("t4_f_delivered", f_seen - f0, 1);
    chk("t4_d_delivered", d_seen - d0, 1);

    // Response with nothing in flight.
    lat = 1;
    @(negedge clk);
    force_rv = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_forced", 32'(instr_rvalid_i), 1);
    chk("t5_no_rvalid", {f_rvalid_o, d_rvalid_o}, 0);
    force_rv = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(protocol_err_o), 1);
    repeat (3) tick();
    chk("t5_err_sticky", 32'(protocol_err_o), 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", 32'(protocol_err_o), 0);
    tick();

    // Reset with two requests outstanding.
    lat = 3;
    f0 = f_seen;
    drive(1'b1, 32'h600, 1'b0, 1'b0, 0);
    tick();
    drive(1'b1, 32'h604, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t6_out_before", 32'(outstanding_o), 1);
    tick();
    rst_i = 1'b1;
    drive(1'b1, 32'h608, 1'b0, 1'b1, 32'h700);
    @(negedge clk);
    chk("t6_rst_gnt", {f_gnt_o, d_gnt_o, instr_req_o}, 0);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 32'h60C, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("t6_out_after", 32'(outstanding_o), 0);
    chk("t6_f_gnt", 32'(f_gnt_o), 1);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0, 0);
    repeat (5) tick();
    chk("t6_delivered", f_seen - f0, 1);
    chk("t6_no_err", 32'(protocol_err_o), 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
